// File: rtl/sweep_ctrl.sv
// -----------------------------------------------------------------------------
// sweep_ctrl
//
// Sequencer for an external universal up/down counter.  Produces a sawtooth
// (count up, natural wrap) or triangle (up/down ping-pong) sweep, paced by a
// programmable prescaler, with clear, preset, hold and abort commands.
//
// Parameters
//   N  counter data width (preset value / d output)
//   P  prescaler width (div input)
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-high reset
//   start     in   begin a sweep (accepted only when idle)
//   stop      in   abort the sweep and return to idle (highest priority)
//   hold      in   freeze stepping and the prescaler while high
//   load_req  in   preset the counter to load_val (second priority)
//   load_val  in   [N] preset value
//   mode      in   0 = sawtooth, 1 = triangle; sampled when a sweep starts
//   div       in   [P] step period minus one, in clk cycles; live while busy
//   max_tick  in   counter is all-ones
//   min_tick  in   counter is zero
//   syn_clr   out  synchronous clear to the counter
//   load      out  parallel load to the counter
//   en        out  count enable
//   up        out  count direction (1 = up)
//   d         out  [N] preset data
//   busy      out  high whenever not idle
//   dir_chg   out  one-cycle pulse in the first cycle after a triangle reversal
//   wrap      out  one-cycle pulse in the cycle after a sawtooth wrap step
// -----------------------------------------------------------------------------
module sweep_ctrl #(
    parameter int N = 8,
    parameter int P = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         hold,
    input  logic         load_req,
    input  logic [N-1:0] load_val,
    input  logic         mode,
    input  logic [P-1:0] div,
    input  logic         max_tick,
    input  logic         min_tick,
    output logic         syn_clr,
    output logic         load,
    output logic         en,
    output logic         up,
    output logic [N-1:0] d,
    output logic         busy,
    output logic         dir_chg,
    output logic         wrap
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_UP   = 3'd2,
        S_DOWN = 3'd3,
        S_LOAD = 3'd4
    } state_t;

    state_t         state_reg, state_next;
    state_t         ret_reg, ret_next;       // where LOAD goes back to
    logic [P-1:0]   pcnt_reg, pcnt_next;
    logic [N-1:0]   d_reg, d_next;
    logic           mode_reg, mode_next;     // sweep shape latched at start
    logic           dir_chg_reg, dir_chg_next;
    logic           wrap_reg, wrap_next;

    logic           running;
    logic           step;
    logic           turn;
    logic           en_int;
    logic           entering_run;
    logic           reversing;

    // -------------------------------------------------------------------------
    // Step / turn decode from registered state and live ticks
    // -------------------------------------------------------------------------
    always_comb begin
        running = (state_reg == S_UP) || (state_reg == S_DOWN);
        step    = running && !hold && (pcnt_reg == div);
        // A triangle sweep reaching an endpoint spends that step turning
        // around instead of counting, so the endpoint dwells one extra period.
        turn    = mode_reg && (((state_reg == S_UP) && max_tick) ||
                               ((state_reg == S_DOWN) && min_tick));
        en_int  = step && !turn;
    end

    // -------------------------------------------------------------------------
    // State register (plus all other sequential state)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            ret_reg     <= S_IDLE;
            pcnt_reg    <= '0;
            d_reg       <= '0;
            mode_reg    <= 1'b0;
            dir_chg_reg <= 1'b0;
            wrap_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ret_reg     <= ret_next;
            pcnt_reg    <= pcnt_next;
            d_reg       <= d_next;
            mode_reg    <= mode_next;
            dir_chg_reg <= dir_chg_next;
            wrap_reg    <= wrap_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: stop > load_req > start; losers are simply dropped
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        ret_next   = ret_reg;
        d_next     = d_reg;
        mode_next  = mode_reg;

        if (stop) begin
            state_next = S_IDLE;
        end else if (load_req && (state_reg != S_LOAD)) begin
            d_next     = load_val;
            state_next = S_LOAD;
            case (state_reg)
                S_IDLE:  ret_next = S_IDLE;
                S_DOWN:  ret_next = S_DOWN;
                default: ret_next = S_UP;    // UP, and CLR resumes as UP
            endcase
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_next = S_CLR;
                        mode_next  = mode;
                    end
                end
                S_CLR:   state_next = S_UP;
                S_UP:    if (step && turn) state_next = S_DOWN;
                S_DOWN:  if (step && turn) state_next = S_UP;
                S_LOAD:  state_next = ret_reg;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Prescaler and event pulses
    // -------------------------------------------------------------------------
    always_comb begin
        entering_run = ((state_next == S_UP) || (state_next == S_DOWN)) &&
                       (state_next != state_reg);
        reversing    = ((state_reg == S_UP) && (state_next == S_DOWN)) ||
                       ((state_reg == S_DOWN) && (state_next == S_UP));

        pcnt_next = pcnt_reg;
        if (entering_run) begin
            pcnt_next = '0;
        end else if (running && !hold) begin
            // Equality compare only: if div is lowered below the current
            // count, the prescaler rolls through 2^P before matching again.
            pcnt_next = (pcnt_reg == div) ? '0 : pcnt_reg + P'(1);
        end

        dir_chg_next = reversing;
        wrap_next    = en_int && max_tick && !mode_reg;
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        syn_clr = (state_reg == S_CLR);
        load    = (state_reg == S_LOAD);
        en      = en_int;
        up      = (state_reg != S_DOWN);
        busy    = (state_reg != S_IDLE);
        d       = d_reg;
        dir_chg = dir_chg_reg;
        wrap    = wrap_reg;
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sweep_ctrl
//
// Drives sweep_ctrl (N=4, P=4) against a 4-bit universal counter kept in the
// bench. A behavioural model of the sweep predicts every output each cycle;
// a vector table and hand-written sequences add directed checks.
// -----------------------------------------------------------------------------
module tb_sweep_ctrl;

    localparam int N = 4;
    localparam int P = 4;

    localparam int PH_IDLE = 0;
    localparam int PH_CLR  = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_LOAD = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, stop, hold, load_req, mode;
    logic [N-1:0] load_val;
    logic [P-1:0] div;
    logic         max_tick, min_tick;
    logic         syn_clr, load, en, up, busy, dir_chg, wrap;
    logic [N-1:0] d;
    logic [N-1:0] q;

    int total = 0;
    int bad   = 0;

    // model state
    int m_phase, m_ret_phase, m_d, m_pc, m_q;
    bit m_down, m_ret_down, m_tri, m_dirchg, m_wrap;

    // values observed in the last cycle, before its clock edge
    bit obs_en, obs_up, obs_syn, obs_load, obs_dirchg, obs_wrap;
    int obs_d, obs_q;

    always #5 clk = ~clk;

    sweep_ctrl #(.N(N), .P(P)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .hold     (hold),
        .load_req (load_req),
        .load_val (load_val),
        .mode     (mode),
        .div      (div),
        .max_tick (max_tick),
        .min_tick (min_tick),
        .syn_clr  (syn_clr),
        .load     (load),
        .en       (en),
        .up       (up),
        .d        (d),
        .busy     (busy),
        .dir_chg  (dir_chg),
        .wrap     (wrap)
    );

    // universal counter driven by the controller
    always @(posedge clk or posedge reset) begin
        if (reset)        q <= '0;
        else if (syn_clr) q <= '0;
        else if (load)    q <= d;
        else if (en)      q <= up ? q + 4'd1 : q - 4'd1;
    end
    assign max_tick = (q == 4'hF);
    assign min_tick = (q == 4'h0);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_phase = PH_IDLE; m_ret_phase = PH_IDLE; m_ret_down = 0;
        m_d = 0; m_pc = 0; m_q = 0; m_down = 0; m_tri = 0;
        m_dirchg = 0; m_wrap = 0;
    endtask

    // Called at posedge+1 with inputs already set; returns at next posedge+1.
    task automatic do_cycle(input bit skip_wait = 0);
        bit run, mx, mn, e_step, e_turn, e_en, e_up, e_syn, e_ld;
        int nq;
        if (!skip_wait) #2;
        obs_en = en; obs_up = up; obs_syn = syn_clr; obs_load = load;
        obs_dirchg = dir_chg; obs_wrap = wrap; obs_d = int'(d); obs_q = int'(q);

        run    = (m_phase == PH_RUN);
        mx     = (m_q == 15);
        mn     = (m_q == 0);
        e_step = run && !hold && (m_pc == int'(div));
        e_turn = m_tri && (m_down ? mn : mx);
        e_en   = e_step && !e_turn;
        e_up   = !(run && m_down);
        e_syn  = (m_phase == PH_CLR);
        e_ld   = (m_phase == PH_LOAD);

        chk("busy",    busy,    m_phase != PH_IDLE);
        chk("en",      en,      e_en);
        chk("up",      up,      e_up);
        chk("syn_clr", syn_clr, e_syn);
        chk("load",    load,    e_ld);
        chk("d",       d,       m_d);
        chk("dir_chg", dir_chg, m_dirchg);
        chk("wrap",    wrap,    m_wrap);

        if (e_syn)     nq = 0;
        else if (e_ld) nq = m_d;
        else if (e_en) nq = e_up ? (m_q + 1) % 16 : (m_q + 15) % 16;
        else           nq = m_q;

        m_wrap   = e_en && mx && !m_tri;
        m_dirchg = 0;
        if (stop) begin
            m_phase = PH_IDLE;
        end else if (load_req && m_phase != PH_LOAD) begin
            m_d = int'(load_val);
            m_ret_phase = (m_phase == PH_IDLE) ? PH_IDLE : PH_RUN;
            m_ret_down  = (m_phase == PH_RUN) && m_down;
            m_phase = PH_LOAD;
        end else if (m_phase == PH_IDLE) begin
            if (start) begin
                m_phase = PH_CLR;
                m_tri = mode;
            end
        end else if (m_phase == PH_CLR) begin
            m_phase = PH_RUN; m_down = 0; m_pc = 0;
        end else if (m_phase == PH_LOAD) begin
            m_phase = m_ret_phase; m_down = m_ret_down; m_pc = 0;
        end else begin
            if (e_step && e_turn) begin
                m_down = !m_down; m_pc = 0; m_dirchg = 1;
            end else if (!hold) begin
                m_pc = (m_pc == int'(div)) ? 0 : (m_pc + 1) % 16;
            end
        end
        m_q = nq;

        @(posedge clk);
        #1;
        chk("count", q, m_q);
    endtask

    task automatic clear_inputs();
        start = 0; stop = 0; hold = 0; load_req = 0; load_val = '0;
        mode = 0; div = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
    endtask

    typedef struct {
        bit st, sp, lr;
        int lv;
        bit md;
        int dv;
        bit e_busy, e_en, e_up, e_syn, e_load;
        int e_q;
    } vec_t;

    function automatic vec_t mk(bit st, bit sp, bit lr, int lv, bit md, int dv,
                                bit eb, bit ee, bit eu, bit es, bit el, int eq);
        vec_t v;
        v.st = st; v.sp = sp; v.lr = lr; v.lv = lv; v.md = md; v.dv = dv;
        v.e_busy = eb; v.e_en = ee; v.e_up = eu; v.e_syn = es; v.e_load = el;
        v.e_q = eq;
        return v;
    endfunction

    initial begin
        vec_t tbl[11];
        int   last_en, cnt, e, qh;
        bit   found;

        // ---------------- table: start, count, preset, combined commands ----
        //            st sp lr lv md dv  busy en up syn ld  q
        tbl[0]  = mk(0, 0, 0, 0, 0, 0,   0,  0, 1, 0,  0,  0);
        tbl[1]  = mk(1, 0, 0, 0, 1, 0,   0,  0, 1, 0,  0,  0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0,   1,  0, 1, 1,  0,  0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0,   1,  1, 1, 0,  0,  0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0,   1,  1, 1, 0,  0,  1);
        tbl[5]  = mk(0, 0, 1, 9, 0, 0,   1,  1, 1, 0,  0,  2);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0,   1,  0, 1, 0,  1,  3);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0,   1,  1, 1, 0,  0,  9);
        tbl[8]  = mk(1, 1, 1, 5, 0, 0,   1,  1, 1, 0,  0, 10);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0,   0,  0, 1, 0,  0, 11);
        tbl[10] = mk(0, 0, 0, 0, 0, 0,   0,  0, 1, 0,  0, 11);

        do_reset();
        chk("reset_busy", busy, 0);
        chk("reset_up", up, 1);
        for (int i = 0; i < 11; i++) begin
            start = tbl[i].st; stop = tbl[i].sp; load_req = tbl[i].lr;
            load_val = 4'(tbl[i].lv); mode = tbl[i].md; div = 4'(tbl[i].dv);
            #2;
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_en", i), en, tbl[i].e_en);
            chk($sformatf("tbl%0d_up", i), up, tbl[i].e_up);
            chk($sformatf("tbl%0d_syn", i), syn_clr, tbl[i].e_syn);
            chk($sformatf("tbl%0d_load", i), load, tbl[i].e_load);
            chk($sformatf("tbl%0d_q", i), q, tbl[i].e_q);
            do_cycle(1);
        end
        chk("dropped_load_d", d, 9);

        // ---------------- triangle trace, div=0 ----------------------------
        do_reset();
        mode = 1; div = 0; start = 1;
        do_cycle();
        start = 0;
        for (int i = 0; i < 40; i++) begin
            do_cycle();
            if (i <= 15)      e = i;
            else if (i == 16) e = 15;
            else if (i <= 31) e = 31 - i;
            else if (i == 32) e = 0;
            else              e = i - 32;
            chk($sformatf("tri_q%0d", i), q, e);
            chk($sformatf("tri_dirchg%0d", i), obs_dirchg, (i == 17 || i == 33));
            if (i == 0) chk("tri_clr", obs_syn, 1);
        end

        // ---------------- sawtooth wrap, div=2 -----------------------------
        do_reset();
        mode = 0; div = 2; start = 1;
        do_cycle();
        start = 0;
        last_en = -1; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            do_cycle();
            if (obs_en) begin
                if (last_en >= 0) chk("saw_period", i - last_en, 3);
                last_en = i;
                if (obs_q == 15) found = 1;
            end
        end
        chk("saw_wrap_seen", found, 1);
        do_cycle();
        chk("saw_wrap_pulse", obs_wrap, 1);
        chk("saw_wrap_q", obs_q, 0);
        do_cycle();
        chk("saw_wrap_one", obs_wrap, 0);

        // ---------------- preset while counting down -----------------------
        do_reset();
        mode = 1; div = 0; start = 1;
        do_cycle();
        start = 0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            do_cycle();
            if (up == 0 && q == 9) found = 1;
        end
        chk("dn9_seen", found, 1);
        load_req = 1; load_val = 4;
        do_cycle();
        load_req = 0;
        do_cycle();
        chk("dn_load_pulse", obs_load, 1);
        chk("dn_load_d", obs_d, 4);
        chk("dn_load_q", q, 4);
        do_cycle();
        chk("dn_up", obs_up, 0);
        chk("dn_q3", q, 3);
        do_cycle();
        chk("dn_q2", q, 2);

        // ---------------- hold at div=1 ------------------------------------
        do_reset();
        mode = 0; div = 1; start = 1;
        do_cycle();
        start = 0;
        for (int i = 0; i < 7; i++) do_cycle();
        hold = 1;
        qh = int'(q);
        for (int i = 0; i < 5; i++) begin
            do_cycle();
            chk("hold_en", obs_en, 0);
            chk("hold_q", q, qh);
        end
        hold = 0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            do_cycle();
            cnt += int'(obs_en);
        end
        chk("hold_resume_ens", cnt, 2);

        // ---------------- reset mid-sweep ----------------------------------
        do_reset();
        mode = 1; div = 0; start = 1;
        do_cycle();
        start = 0;
        for (int i = 0; i < 20; i++) do_cycle();
        load_req = 1; load_val = 7;
        do_cycle();
        load_req = 0;
        do_cycle();
        do_cycle();
        chk("pre_reset_up", up, 0);
        chk("pre_reset_d", d, 7);
        #2;
        reset = 1;
        #1;
        chk("rst_syn_clr", syn_clr, 0);
        chk("rst_load", load, 0);
        chk("rst_en", en, 0);
        chk("rst_up", up, 1);
        chk("rst_d", d, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dir_chg", dir_chg, 0);
        chk("rst_wrap", wrap, 0);
        @(posedge clk);
        #1;
        reset = 0;
        m_reset();
        mode = 1; start = 1;
        do_cycle();
        start = 0;
        do_cycle();
        chk("restart_clr", obs_syn, 1);

        // ---------------- randomized against the model ---------------------
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            stop     = ($urandom_range(0, 99) < 1);
            load_req = ($urandom_range(0, 99) < 5);
            start    = ($urandom_range(0, 99) < 15);
            hold     = ($urandom_range(0, 99) < 20);
            load_val = 4'($urandom);
            mode     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 4)
                div = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            do_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
